// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF and D requests onto one single-port synchronous memory.
// Optional macro ARB_RR_EN alternates grants on ties; undefined gives fixed D-over-IF priority.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   localparam logic [2:0] LAT = 3'(MEM_LAT);

   state_t     state;
   state_t     next_state;
   logic       grant;
   logic       grant_d;
   logic       owner_d;
   logic       lat_we;
   logic [2:0] cnt;
`ifdef ARB_RR_EN
   logic       last_d;
`endif

   generate
      if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
         $error("mem_arbiter: MEM_LAT must be in 1..4");
      end
   endgenerate

   always_comb begin
      next_state = state;
      grant      = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               grant = 1'b1;
`ifdef ARB_RR_EN
               grant_d = (if_req && d_req) ? !last_d : d_req;
`else
               grant_d = d_req;
`endif
               next_state = ACCESS;
            end
         end
         ACCESS:  next_state = WAIT;
         WAIT:    if (cnt == 3'd1) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state, so mem_en is high exactly while in ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         owner_d   <= 1'b0;
         lat_we    <= 1'b0;
         cnt       <= '0;
`ifdef ARB_RR_EN
         last_d    <= 1'b0;
`endif
      end else begin
         state  <= next_state;
         busy   <= (next_state != IDLE);
         mem_en <= grant;
         mem_we <= grant & grant_d & d_we;
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         if (grant) begin
            owner_d  <= grant_d;
            lat_we   <= grant_d & d_we;
            mem_addr <= grant_d ? d_addr : if_addr;
            if (grant_d) mem_wdata <= d_wdata;
`ifdef ARB_RR_EN
            last_d   <= grant_d;
`endif
         end
         if (state == ACCESS) begin
            cnt <= LAT;
         end else if (state == WAIT) begin
            cnt <= cnt - 3'd1;
            // Last wait cycle: read data is valid on the memory port now.
            if (cnt == 3'd1) begin
               if_ack <= !owner_d;
               d_ack  <= owner_d;
               if (!lat_we) begin
                  if (owner_d) d_rdata  <= mem_rdata;
                  else         if_rdata <= mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch requester (IF) and data requester (D). Needed for the unified-memory build of the core.
- Serialises requests with a req/ack handshake, drives the memory port and returns read data.
- Sits between the core (fetch and load/store paths) and the memory macro.

Parameters:
- ADDR_W, 32: address width, all ports.
- DATA_W, 32: data width, all ports.
- MEM_LAT, 1: cycles from mem_en to valid mem_rdata. Legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_W  fetch address.
- if_ack  output  1  one-cycle completion pulse to IF.
- if_rdata  output  DATA_W  fetched word; valid with if_ack.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle completion pulse to D.
- d_rdata  output  DATA_W  load data; valid with d_ack on reads.
- mem_en  output  1  memory access strobe, one cycle per transaction.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, MEM_LAT cycles after mem_en.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous, active-high. All outputs and state are registered.
- Reset values: every output is 0; FSM = IDLE; last-grant flag = IF; latency counter = 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Samples if_req and d_req.
  - If either is high, latches owner, addr, we and wdata (IF always read, we=0), then moves to ACCESS.
  - If neither is high, stays in IDLE.
- ACCESS: mem_en=1 for exactly one cycle, with mem_we, mem_addr and mem_wdata from the latch. Loads counter = MEM_LAT; moves to WAIT.
- WAIT:
  - Decrements counter each cycle.
  - When the counter reaches 1, captures mem_rdata into the owner's rdata register (reads only) and moves to DONE.
- DONE: asserts the owner's ack for one cycle, then moves to IDLE. Request inputs are ignored in DONE.
- Latency: request sampled in IDLE at cycle T gives mem_en at T+1 and ack at T+MEM_LAT+2. Back-to-back transactions take one per MEM_LAT+3 cycles.
- Priority (default): when both requests are high in the same IDLE cycle, D wins (it belongs to the older instruction). IF waits with req held.
- Read data registers:
  - if_rdata and d_rdata update only on a read completion for their own owner.
  - They hold their value otherwise, including across writes.
- mem_en/mem_we: low in every state except ACCESS. mem_addr and mem_wdata hold their last value when idle.
- Requester rules:
  - addr/we/wdata must stay stable while req is high. The arbiter latches them at grant regardless.
  - Requester drops req in the ack cycle unless it starts a new transaction. A req still high in the next IDLE cycle is treated as a new request.
- Protocol violation: req dropped before ack. The transaction still completes and is acked; no abort.
- Reset mid-operation:
  - Asynchronous return to IDLE with all outputs 0. mem_en falls immediately.
  - The in-flight access is abandoned with no ack.
  - Requests still high after rst release are served as new requests.
- MEM_LAT outside 1..4 is illegal; the implementation flags it with an elaboration-time error.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - On a tie, grant goes to the requester not granted last, using the last-grant flag (reset value IF, so the first tie goes to D).
  - The flag updates on every grant, including uncontended ones.
- Undefined: fixed D-over-IF priority, no last-grant flag. IF can starve while d_req stays high.

Test Plan:
- Reset: assert rst with both reqs high → all outputs 0, busy=0; after release D is granted first.
- IF read, MEM_LAT=1, if_addr=0x00000010, memory word 0x00500093:
  - mem_en=1, mem_addr=0x10, mem_we=0 at cycle 1.
  - if_ack=1, if_rdata=0x00500093 at cycle 3.
  - busy high for cycles 1–3.
- Tie: if_req and d_req (read, 0x100) both high at cycle 0:
  - D gets mem_en at cycle 1 and d_ack at cycle 3.
  - IF gets mem_en at cycle 5 and if_ack at cycle 7.
- D write, d_addr=0x200, d_wdata=0xDEADBEEF:
  - mem_en=mem_we=1 with that addr/data at cycle 1.
  - d_ack at cycle 3; d_rdata unchanged.
- Reset mid-op, MEM_LAT=3, rst pulse at cycle 2:
  - Outputs go to 0 asynchronously; no ack follows.
  - After release, the held request restarts with mem_en one cycle after the first IDLE cycle.
- Starvation check, both reqs held continuously for 4 grants:
  - Without ARB_RR_EN: D, D, D, D.
  - With ARB_RR_EN: D, IF, D, IF.
